uart_step_ctrl: RTL and testbench
=================================

UART_STEP_CTRL -- requirements
Module: uart_step_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1200000, max CLK cycles allowed between frame bytes.
REQ-002 SHALL have parameter LOW_CYCLES, default 2, CLK cycles that stepClock is held low per step.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2, CLK cycles after the stepClock rise before readData/readFlag are sampled.
REQ-004 CLK  in  1  system clock; one clock, all logic on posedge CLK.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 RXbuffer  in  8  received UART byte, valid while RXready=1.
REQ-007 RXready  in  1  one-cycle strobe per received byte.
REQ-008 TXbusy  in  1  UART transmitter busy.
REQ-009 TXbuffer  out  8  byte to transmit.
REQ-010 TXstart  out  1  one-cycle transmit request.
REQ-011 stepWord  out  32  control word driven to the control unit.
REQ-012 stepClock  out  1  stepped datapath clock, idle high.
REQ-013 readData  in  16  datapath readback value (ALU accumulator).
REQ-014 readFlag  in  1  datapath status bit (ALU overflow).
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frameErr  out  1  one-cycle pulse on inter-byte timeout.
REQ-017 rxDrop  out  1  one-cycle pulse when RXready arrives outside IDLE/RECV.

Function
REQ-018 States SHALL be IDLE, RECV, CLK_LO, CLK_HI, SEND, TX_WAIT.
REQ-019 IDLE: on RXready with RXbuffer=0xA5 go RECV with byte index 0; any other byte ignored, no pulse.
REQ-020 RECV: each RXready stores RXbuffer into shadow bits [8*i+7:8*i], i=0..3 (little-endian), and reloads the timeout counter.
REQ-021 After byte i=3 the full shadow SHALL be copied to stepWord in the same cycle and state SHALL go CLK_LO; stepWord SHALL change at no other time.
REQ-022 RECV: if TIMEOUT_CYCLES elapse with no RXready, pulse frameErr, discard shadow, go IDLE; stepWord unchanged.
REQ-023 CLK_LO: stepClock=0 for exactly LOW_CYCLES cycles, then CLK_HI.
REQ-024 CLK_HI: stepClock=1; after SETTLE_CYCLES cycles capture {readFlag, readData} into a response register, then SEND with response index 0.
REQ-025 Response SHALL be 3 bytes in order: readData[7:0], readData[15:8], {7'b0, readFlag}.
REQ-026 SEND: when TXbusy=0, drive TXbuffer and pulse TXstart for one cycle, go TX_WAIT; while TXbusy=1 hold.
REQ-027 TX_WAIT: ignore TXbusy for 2 guard cycles, then on TXbusy=0 advance index; after index 2 go IDLE, else SEND.
REQ-028 TXbuffer SHALL be stable from the TXstart cycle until the next TXstart.
REQ-029 RXready in CLK_LO, CLK_HI, SEND or TX_WAIT SHALL be dropped and pulse rxDrop in the same cycle.
REQ-030 Latency from 4th data byte RXready to first TXstart SHALL be LOW_CYCLES+SETTLE_CYCLES+2 cycles when TXbusy=0.
REQ-031 Timeout and phase counters SHALL saturate, never wrap.

Reset
REQ-032 On RST: state IDLE, stepWord=0, stepClock=1, TXstart=0, TXbuffer=0, busy=0, frameErr=0, rxDrop=0, counters and indices 0.
REQ-033 RST mid-frame or mid-step SHALL abandon the operation in the next cycle without a stepClock edge or TXstart.

Structure
REQ-034 Package uart_step_pkg SHALL hold the state enumeration, SYNC_BYTE=0xA5, FRAME_BYTES=4, RESP_BYTES=3.
REQ-035 One sub-module step_timer (loadable saturating down-counter with done flag) SHALL serve timeout, low-phase and settle timing.

Verification
REQ-036 Frame A5 78 56 34 12, readData=0xBEEF, readFlag=1 -> stepWord=0x12345678, one stepClock low pulse of 2 cycles, TX bytes EF BE 01.
REQ-037 Bytes 00 FF then A5 01 00 00 00 -> leading bytes ignored, stepWord=0x00000001, 3 TX bytes.
REQ-038 A5 11 22 then silence > TIMEOUT_CYCLES -> frameErr one pulse, no stepClock edge, no TXstart, stepWord unchanged.
REQ-039 TXbusy held high 50 cycles at SEND, RXready during wait -> TXstart only after TXbusy falls, rxDrop pulses once.
REQ-040 RST asserted during CLK_LO -> stepClock=1 next cycle, state IDLE, no TX bytes.

Source files
------------

// File: rtl/uart_step_ctrl_pkg.sv
// Shared types and constants for the UART-driven single-step controller.
package uart_step_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CLK_LO,
        CLK_HI,
        SEND,
        TX_WAIT
    } state_t;

    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam int         FRAME_BYTES     = 4;
    localparam int         RESP_BYTES      = 3;
    localparam int         TX_GUARD_CYCLES = 2;

    // Response layout: accumulator low byte, high byte, then the status flag.
    function automatic logic [7:0] resp_byte(input logic [16:0] resp, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = resp[7:0];
            2'd1:    b = resp[15:8];
            default: b = {7'b0, resp[16]};
        endcase
        return b;
    endfunction

    // A phase of N cycles ends when the timer reaches zero, so load N-1.
    function automatic int phase_load(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

    function automatic int bits_for(input int value);
        return (value < 2) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/uart_step_ctrl_if.sv
// Byte-level UART handshake between the controller (master) and the UART core (slave).
interface uart_step_ctrl_if;
    logic [7:0] RXbuffer;
    logic       RXready;
    logic       TXbusy;
    logic [7:0] TXbuffer;
    logic       TXstart;

    modport master (
        input  RXbuffer, RXready, TXbusy,
        output TXbuffer, TXstart
    );

    modport slave (
        output RXbuffer, RXready, TXbusy,
        input  TXbuffer, TXstart
    );
endinterface

// File: rtl/uart_step_ctrl_step_timer.sv
// Loadable down-counter that sticks at zero; done is high while the count is zero.
module step_timer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/uart_step_ctrl.sv
// Receives a sync-prefixed 32-bit step word over UART, pulses the stepped clock
// once, then returns the datapath readback as three UART bytes.
module uart_step_ctrl
    import uart_step_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1200000,
    parameter int LOW_CYCLES     = 2,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    uart_step_ctrl_if.master        uart,
    output logic [31:0]             stepWord,
    output logic                    stepClock,
    input  logic [15:0]             readData,
    input  logic                    readFlag,
    output logic                    busy,
    output logic                    frameErr,
    output logic                    rxDrop
);

    localparam int MAX_LOAD_A = (TIMEOUT_CYCLES > LOW_CYCLES) ? TIMEOUT_CYCLES : LOW_CYCLES;
    localparam int MAX_LOAD   = (MAX_LOAD_A > SETTLE_CYCLES) ? MAX_LOAD_A : SETTLE_CYCLES;
    localparam int TIMER_W    = bits_for(MAX_LOAD);

    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] LOW_LOAD     = TIMER_W'(phase_load(LOW_CYCLES));
    localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(phase_load(SETTLE_CYCLES));

    state_t       state_q,       state_d;
    logic [1:0]   byte_idx_q,    byte_idx_d;
    logic [1:0]   resp_idx_q,    resp_idx_d;
    logic [1:0]   guard_q,       guard_d;
    logic [23:0]  shadow_q,      shadow_d;
    logic [16:0]  resp_q,        resp_d;
    logic [31:0]  step_word_q,   step_word_d;
    logic         step_clock_q,  step_clock_d;
    logic [7:0]   tx_buffer_q,   tx_buffer_d;
    logic         tx_start_q,    tx_start_d;
    logic         frame_err_q,   frame_err_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_val;
    logic               tmr_done;

    step_timer #(.WIDTH(TIMER_W)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        resp_idx_d   = resp_idx_q;
        guard_d      = guard_q;
        shadow_d     = shadow_q;
        resp_d       = resp_q;
        step_word_d  = step_word_q;
        tx_buffer_d  = tx_buffer_q;
        tx_start_d   = 1'b0;
        frame_err_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = TIMEOUT_LOAD;

        case (state_q)
            IDLE: begin
                if (uart.RXready && uart.RXbuffer == SYNC_BYTE) begin
                    state_d    = RECV;
                    byte_idx_d = 2'd0;
                    shadow_d   = '0;
                    tmr_load   = 1'b1;
                end
            end
            RECV: begin
                if (uart.RXready) begin
                    tmr_load = 1'b1;
                    case (byte_idx_q)
                        2'd0: shadow_d[7:0]   = uart.RXbuffer;
                        2'd1: shadow_d[15:8]  = uart.RXbuffer;
                        2'd2: shadow_d[23:16] = uart.RXbuffer;
                        default: ;
                    endcase
                    if (byte_idx_q == 2'(FRAME_BYTES - 1)) begin
                        // Last byte goes straight into the word; the shadow only holds the first three.
                        step_word_d  = {uart.RXbuffer, shadow_q};
                        byte_idx_d   = 2'd0;
                        tmr_load_val = LOW_LOAD;
                        state_d      = CLK_LO;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else if (tmr_done) begin
                    frame_err_d = 1'b1;
                    shadow_d    = '0;
                    byte_idx_d  = 2'd0;
                    state_d     = IDLE;
                end
            end
            CLK_LO: begin
                if (tmr_done) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = SETTLE_LOAD;
                    state_d      = CLK_HI;
                end
            end
            CLK_HI: begin
                if (tmr_done) begin
                    resp_d     = {readFlag, readData};
                    resp_idx_d = 2'd0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (!uart.TXbusy) begin
                    tx_buffer_d = resp_byte(resp_q, resp_idx_q);
                    tx_start_d  = 1'b1;
                    guard_d     = 2'(TX_GUARD_CYCLES);
                    state_d     = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // The UART may not raise TXbusy until a cycle or two after TXstart.
                if (guard_q != 2'd0) begin
                    guard_d = guard_q - 2'd1;
                end else if (!uart.TXbusy) begin
                    if (resp_idx_q == 2'(RESP_BYTES - 1)) begin
                        resp_idx_d = 2'd0;
                        state_d    = IDLE;
                    end else begin
                        resp_idx_d = resp_idx_q + 2'd1;
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        step_clock_d = (state_d != CLK_LO);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            byte_idx_q   <= 2'd0;
            resp_idx_q   <= 2'd0;
            guard_q      <= 2'd0;
            shadow_q     <= '0;
            resp_q       <= '0;
            step_word_q  <= '0;
            step_clock_q <= 1'b1;
            tx_buffer_q  <= '0;
            tx_start_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            resp_idx_q   <= resp_idx_d;
            guard_q      <= guard_d;
            shadow_q     <= shadow_d;
            resp_q       <= resp_d;
            step_word_q  <= step_word_d;
            step_clock_q <= step_clock_d;
            tx_buffer_q  <= tx_buffer_d;
            tx_start_q   <= tx_start_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign stepWord      = step_word_q;
    assign stepClock     = step_clock_q;
    assign uart.TXbuffer = tx_buffer_q;
    assign uart.TXstart  = tx_start_q;
    assign frameErr      = frame_err_q;
    assign busy          = (state_q != IDLE);
    // Flagged in the cycle the byte arrives, so it is decoded from the current state.
    assign rxDrop        = uart.RXready &&
                           (state_q inside {CLK_LO, CLK_HI, SEND, TX_WAIT});

endmodule

// File: tb/tb_uart_step_ctrl.sv
// Directed bench for uart_step_ctrl: frames, leading garbage, timeout, TX back-pressure, reset mid-step.
module tb_uart_step_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] read_data = 16'h0000;
    logic        read_flag = 1'b0;
    logic [31:0] step_word;
    logic        step_clock;
    logic        busy;
    logic        frame_err;
    logic        rx_drop;

    uart_step_ctrl_if u_if ();

    uart_step_ctrl #(
        .TIMEOUT_CYCLES (40),
        .LOW_CYCLES     (2),
        .SETTLE_CYCLES  (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .uart      (u_if),
        .stepWord  (step_word),
        .stepClock (step_clock),
        .readData  (read_data),
        .readFlag  (read_flag),
        .busy      (busy),
        .frameErr  (frame_err),
        .rxDrop    (rx_drop)
    );

    always #5 CLK = ~CLK;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int last_rx_cyc = 0;

    // Event monitor, sampled on the falling edge.
    int         cyc = 0;
    int         sc_falls = 0;
    int         sc_low_run = 0;
    int         sc_last_low = 0;
    int         fe_cnt = 0;
    int         drop_cnt = 0;
    int         tx_n = 0;
    logic [7:0] tx_log [0:63];
    int         tx_cyc [0:63];
    logic       prev_sc = 1'b1;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (prev_sc === 1'b1 && step_clock === 1'b0) sc_falls <= sc_falls + 1;
        if (step_clock === 1'b0) begin
            sc_low_run <= sc_low_run + 1;
        end else if (sc_low_run != 0) begin
            sc_last_low <= sc_low_run;
            sc_low_run  <= 0;
        end
        prev_sc <= step_clock;
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (rx_drop === 1'b1) drop_cnt <= drop_cnt + 1;
        if (u_if.TXstart === 1'b1 && tx_n < 64) begin
            tx_log[tx_n] <= u_if.TXbuffer;
            tx_cyc[tx_n] <= cyc;
            tx_n         <= tx_n + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK);
        #1;
        u_if.RXbuffer = b;
        u_if.RXready  = 1'b1;
        last_rx_cyc   = cyc;
        @(posedge CLK);
        #1;
        u_if.RXready  = 1'b0;
        $display("rx byte %h at cycle %0d", b, last_rx_cyc);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(3);
        check_cnt++; if (step_word !== 32'h0) $display("FAIL reset_stepword: got %h want %h", step_word, 32'h0); else pass_cnt++;
        check_cnt++; if (step_clock !== 1'b1) $display("FAIL reset_stepclock: got %b want 1", step_clock); else pass_cnt++;
        check_cnt++; if (u_if.TXstart !== 1'b0) $display("FAIL reset_txstart: got %b want 0", u_if.TXstart); else pass_cnt++;
        check_cnt++; if (u_if.TXbuffer !== 8'h00) $display("FAIL reset_txbuffer: got %h want 00", u_if.TXbuffer); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        check_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frameerr: got %b want 0", frame_err); else pass_cnt++;
        check_cnt++; if (rx_drop !== 1'b0) $display("FAIL reset_rxdrop: got %b want 0", rx_drop); else pass_cnt++;
        RST = 1'b0;
        step(2);
        $display("test_reset done");
    endtask

    task automatic test_basic_frame();
        int  base, falls0, fe0, rx4;
        bit  ok;
        read_data = 16'hBEEF;
        read_flag = 1'b1;
        base   = tx_n;
        falls0 = sc_falls;
        fe0    = fe_cnt;
        send_byte(8'hA5);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        rx4 = last_rx_cyc;
        wait_idle(ok);
        step(2);
        check_cnt++; if (!ok) $display("FAIL basic_idle: busy=%b still high after wait, want 0", busy); else pass_cnt++;
        check_cnt++; if (step_word !== 32'h12345678) $display("FAIL basic_stepword: got %h want 12345678", step_word); else pass_cnt++;
        check_cnt++; if (sc_falls - falls0 !== 1) $display("FAIL basic_falls: got %0d want 1", sc_falls - falls0); else pass_cnt++;
        check_cnt++; if (sc_last_low !== 2) $display("FAIL basic_lowlen: got %0d want 2", sc_last_low); else pass_cnt++;
        check_cnt++; if (tx_n - base !== 3) $display("FAIL basic_txcount: got %0d want 3", tx_n - base); else pass_cnt++;
        check_cnt++; if (tx_log[base] !== 8'hEF) $display("FAIL basic_tx0: got %h want EF", tx_log[base]); else pass_cnt++;
        check_cnt++; if (tx_log[base+1] !== 8'hBE) $display("FAIL basic_tx1: got %h want BE", tx_log[base+1]); else pass_cnt++;
        check_cnt++; if (tx_log[base+2] !== 8'h01) $display("FAIL basic_tx2: got %h want 01", tx_log[base+2]); else pass_cnt++;
        check_cnt++; if (tx_cyc[base] - rx4 !== 6) $display("FAIL basic_latency: got %0d want 6", tx_cyc[base] - rx4); else pass_cnt++;
        check_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL basic_frameerr: got %0d want 0", fe_cnt - fe0); else pass_cnt++;
        $display("test_basic_frame done");
    endtask

    task automatic test_leading_bytes();
        int base, drop0;
        bit ok;
        read_data = 16'h1234;
        read_flag = 1'b0;
        base  = tx_n;
        drop0 = drop_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        check_cnt++; if (busy !== 1'b0) $display("FAIL lead_ignored: busy got %b want 0", busy); else pass_cnt++;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle(ok);
        step(2);
        check_cnt++; if (!ok) $display("FAIL lead_idle: busy=%b still high after wait, want 0", busy); else pass_cnt++;
        check_cnt++; if (step_word !== 32'h00000001) $display("FAIL lead_stepword: got %h want 00000001", step_word); else pass_cnt++;
        check_cnt++; if (tx_n - base !== 3) $display("FAIL lead_txcount: got %0d want 3", tx_n - base); else pass_cnt++;
        check_cnt++; if (tx_log[base] !== 8'h34) $display("FAIL lead_tx0: got %h want 34", tx_log[base]); else pass_cnt++;
        check_cnt++; if (tx_log[base+1] !== 8'h12) $display("FAIL lead_tx1: got %h want 12", tx_log[base+1]); else pass_cnt++;
        check_cnt++; if (tx_log[base+2] !== 8'h00) $display("FAIL lead_tx2: got %h want 00", tx_log[base+2]); else pass_cnt++;
        check_cnt++; if (drop_cnt - drop0 !== 0) $display("FAIL lead_rxdrop: got %0d want 0", drop_cnt - drop0); else pass_cnt++;
        $display("test_leading_bytes done");
    endtask

    task automatic test_timeout();
        int base, falls0, fe0;
        base   = tx_n;
        falls0 = sc_falls;
        fe0    = fe_cnt;
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        check_cnt++; if (busy !== 1'b1) $display("FAIL timeout_busy_recv: got %b want 1", busy); else pass_cnt++;
        step(60);
        check_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL timeout_frameerr: got %0d want 1", fe_cnt - fe0); else pass_cnt++;
        check_cnt++; if (sc_falls - falls0 !== 0) $display("FAIL timeout_falls: got %0d want 0", sc_falls - falls0); else pass_cnt++;
        check_cnt++; if (tx_n - base !== 0) $display("FAIL timeout_txcount: got %0d want 0", tx_n - base); else pass_cnt++;
        check_cnt++; if (step_word !== 32'h00000001) $display("FAIL timeout_stepword: got %h want 00000001", step_word); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL timeout_busy: got %b want 0", busy); else pass_cnt++;
        $display("test_timeout done");
    endtask

    task automatic test_tx_backpressure();
        int base, drop0, rel_cyc;
        bit ok;
        read_data    = 16'h00AA;
        read_flag    = 1'b0;
        u_if.TXbusy  = 1'b1;
        base  = tx_n;
        drop0 = drop_cnt;
        send_byte(8'hA5);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        step(20);
        send_byte(8'h55);
        step(28);
        check_cnt++; if (tx_n - base !== 0) $display("FAIL hold_no_tx: got %0d want 0", tx_n - base); else pass_cnt++;
        check_cnt++; if (drop_cnt - drop0 !== 1) $display("FAIL hold_rxdrop: got %0d want 1", drop_cnt - drop0); else pass_cnt++;
        check_cnt++; if (busy !== 1'b1) $display("FAIL hold_busy: got %b want 1", busy); else pass_cnt++;
        u_if.TXbusy = 1'b0;
        rel_cyc = cyc;
        wait_idle(ok);
        step(2);
        check_cnt++; if (!ok) $display("FAIL hold_idle: busy=%b still high after wait, want 0", busy); else pass_cnt++;
        check_cnt++; if (tx_n - base !== 3) $display("FAIL hold_txcount: got %0d want 3", tx_n - base); else pass_cnt++;
        check_cnt++; if (tx_cyc[base] <= rel_cyc) $display("FAIL hold_tx_after_release: got cycle %0d want > %0d", tx_cyc[base], rel_cyc); else pass_cnt++;
        check_cnt++; if (tx_log[base] !== 8'hAA) $display("FAIL hold_tx0: got %h want AA", tx_log[base]); else pass_cnt++;
        check_cnt++; if (tx_log[base+2] !== 8'h00) $display("FAIL hold_tx2: got %h want 00", tx_log[base+2]); else pass_cnt++;
        check_cnt++; if (step_word !== 32'hEFBEADDE) $display("FAIL hold_stepword: got %h want EFBEADDE", step_word); else pass_cnt++;
        $display("test_tx_backpressure done");
    endtask

    task automatic test_reset_mid_step();
        int base, falls0;
        base   = tx_n;
        falls0 = sc_falls;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check_cnt++; if (step_clock !== 1'b0) $display("FAIL rstmid_in_clklo: stepClock got %b want 0", step_clock); else pass_cnt++;
        RST = 1'b1;
        step(1);
        check_cnt++; if (step_clock !== 1'b1) $display("FAIL rstmid_stepclock: got %b want 1", step_clock); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
        check_cnt++; if (step_word !== 32'h0) $display("FAIL rstmid_stepword: got %h want 00000000", step_word); else pass_cnt++;
        RST = 1'b0;
        step(30);
        check_cnt++; if (tx_n - base !== 0) $display("FAIL rstmid_txcount: got %0d want 0", tx_n - base); else pass_cnt++;
        check_cnt++; if (sc_falls - falls0 !== 1) $display("FAIL rstmid_falls: got %0d want 1", sc_falls - falls0); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_stays_idle: got %b want 0", busy); else pass_cnt++;
        $display("test_reset_mid_step done");
    endtask

    initial begin
        u_if.RXbuffer = 8'h00;
        u_if.RXready  = 1'b0;
        u_if.TXbusy   = 1'b0;
        test_reset();
        test_basic_frame();
        test_leading_bytes();
        test_timeout();
        test_tx_backpressure();
        test_reset_mid_step();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
